negator_arbiter: RTL
====================

NEGATOR_ARBITER -- requirements
Module: negator_arbiter

Interface
REQ-001 Parameter nrOfBits, default 8, data width of every operand and result; legal range 2..32.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-004 req_valid  input  4  per-requester operand valid; bit i = requester i.
REQ-005 req_data  input  4*nrOfBits  operands; requester i at bits [i*nrOfBits +: nrOfBits].
REQ-006 req_ready  output  4  one-hot (or zero) acceptance; operand i taken when req_valid[i] & req_ready[i].
REQ-007 out_valid  output  1  result register holds a valid result.
REQ-008 out_data  output  nrOfBits  registered two's-complement negation of the accepted operand.
REQ-009 out_id  output  2  index of the requester that produced out_data.
REQ-010 out_ovf  output  1  accepted operand was the most negative value (100...0).
REQ-011 out_ready  input  1  consumer accepts result when out_valid & out_ready.

Function
REQ-012 The block SHALL share one negator among 4 requesters with round-robin priority, one operation per cycle at most.
REQ-013 Two states: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on accept; FULL->EMPTY on drain with no accept; FULL->FULL on drain with accept or on stall.
REQ-014 Accept enabled when state EMPTY, or FULL with out_ready=1 (same-cycle drain and refill, full throughput).
REQ-015 When accept enabled, req_ready SHALL be one-hot on the first requester with req_valid=1 searching from (last_grant+1) mod 4 upward; otherwise req_ready=0.
REQ-016 req_ready is combinational from req_valid, state, out_ready and last_grant; no req_valid->req_ready dependency beyond the priority search.
REQ-017 On accept, next cycle: out_data = (-operand) mod 2^nrOfBits, out_id = granted index, out_ovf = (operand == 2^(nrOfBits-1)), last_grant = granted index; latency exactly 1 cycle.
REQ-018 When FULL and out_ready=0, out_data/out_id/out_ovf SHALL hold stable and req_ready=0.
REQ-019 Operand 0 SHALL yield out_data=0, out_ovf=0.
REQ-020 last_grant SHALL change only on accept; idle cycles do not rotate priority.
REQ-021 Requester with req_valid held high SHALL be granted within 4 accept-enabled cycles (starvation bound).

Reset
REQ-022 reset_n=0 at a rising edge SHALL set state EMPTY, out_valid=0, out_data=0, out_id=0, out_ovf=0, last_grant=3 (requester 0 first).
REQ-023 Reset mid-operation SHALL discard any held result; req_ready=0 while reset_n=0.

Configuration
REQ-024 Macro NEGATOR_ARBITER_SAT_EN: when defined, most-negative operand SHALL produce out_data = 2^(nrOfBits-1)-1 (saturated) with out_ovf=1; when undefined, out_data = operand (wrap) with out_ovf=1.

Structure
REQ-025 Package negator_arbiter_pkg SHALL hold NUM_REQ=4, ID_W=2, and the state enum (EMPTY, FULL).
REQ-026 Negation SHALL be performed by one instance of existing sub-module Negator (nrOfBits passed through); saturation mux sits outside it.

Verification
REQ-027 nrOfBits=8, reset, req_valid=0001, data0=0x05, out_ready=1 -> req_ready=0001; next cycle out_valid=1, out_data=0xFB, out_id=0, out_ovf=0.
REQ-028 All four valid continuously, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, out_id follows one cycle later.
REQ-029 data2=0x80, only requester 2 valid -> out_ovf=1; out_data=0x80 without macro, 0x7F with NEGATOR_ARBITER_SAT_EN.
REQ-030 FULL with out_ready=0 for 3 cycles, all valid -> req_ready=0, outputs stable; release out_ready -> drain and new accept same cycle.
REQ-031 reset_n=0 while FULL -> next cycle out_valid=0, outputs 0; after release requester 0 granted first.

Source files
------------

// File: rtl/negator_arbiter_pkg.sv
// Shared definitions for the negator arbiter.
//   NUM_REQ : number of requesters sharing the negator
//   ID_W    : width of a requester index
//   state_t : result register occupancy (EMPTY / FULL)
package negator_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/Negator.sv
// Combinational two's-complement negator.
//   nrOfBits : operand / result width
// Ports:
//   operand  : value to negate
//   result   : (-operand) mod 2^nrOfBits
module Negator #(
  parameter int nrOfBits = 8
) (
  input  logic [nrOfBits-1:0] operand,
  output logic [nrOfBits-1:0] result
);

  logic signed [nrOfBits-1:0] operand_s;

  assign operand_s = $signed(operand);
  assign result    = -operand_s;

endmodule

// File: rtl/negator_arbiter.sv
// Four requesters share one negator under round-robin priority. A single
// result register holds the negated operand until the consumer drains it;
// drain and refill may happen in the same cycle.
//
// Build option: define NEGATOR_ARBITER_SAT_EN to saturate the most negative
// operand to the most positive value instead of letting it wrap.
//
// Ports:
//   clock      : sole clock, rising edge
//   reset_n    : synchronous active-low reset
//   req_valid  : per-requester operand valid
//   req_data   : operands, requester i at [i*nrOfBits +: nrOfBits]
//   req_ready  : one-hot (or zero) grant / acceptance
//   out_valid  : result register holds a result
//   out_data   : negated operand
//   out_id     : requester index that produced out_data
//   out_ovf    : operand was the most negative value
//   out_ready  : consumer takes the result when out_valid & out_ready
module negator_arbiter
  import negator_arbiter_pkg::*;
#(
  parameter int nrOfBits = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*nrOfBits-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  output logic [nrOfBits-1:0]          out_data,
  output logic [ID_W-1:0]              out_id,
  output logic                         out_ovf,
  input  logic                         out_ready
);

`ifdef NEGATOR_ARBITER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [nrOfBits-1:0] MIN_VAL = {1'b1, {(nrOfBits-1){1'b0}}};
  localparam logic [nrOfBits-1:0] MAX_VAL = {1'b0, {(nrOfBits-1){1'b1}}};

  state_t                  state;
  logic [ID_W-1:0]         last_grant;

  logic                    accept_en;
  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         grant_id;
  logic                    found;
  logic [ID_W-1:0]         cand;

  logic                    vld_p0;
  logic [nrOfBits-1:0]     operand_p0;
  logic [nrOfBits-1:0]     neg_p0;
  logic                    min_p0;

  // Only the most negative value can overflow; the wrapped negation of it
  // equals the operand itself, so saturation only needs to patch that case.
  function automatic logic [nrOfBits-1:0] saturate(
    input logic [nrOfBits-1:0] neg,
    input logic                is_min
  );
    if (SAT_EN && is_min) begin
      saturate = MAX_VAL;
    end else begin
      saturate = neg;
    end
  endfunction

  // Stage p0: arbitration and negation (combinational)
  assign accept_en = reset_n && ((state == EMPTY) || out_ready);

  // Search starts one past the last grant; the 2-bit index wraps naturally.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_grant + ID_W'(k);
      if (accept_en && !found && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_id    = cand;
        found       = 1'b1;
      end
    end
  end

  assign req_ready  = grant;
  assign vld_p0     = found;
  assign operand_p0 = req_data[int'(grant_id)*nrOfBits +: nrOfBits];
  assign min_p0     = (operand_p0 == MIN_VAL);

  Negator #(
    .nrOfBits (nrOfBits)
  ) u_negator (
    .operand (operand_p0),
    .result  (neg_p0)
  );

  // Stage p1: result register and occupancy state
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_id     <= '0;
      out_ovf    <= 1'b0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (vld_p0) begin
      state      <= FULL;
      out_data   <= saturate(neg_p0, min_p0);
      out_id     <= grant_id;
      out_ovf    <= min_p0;
      last_grant <= grant_id;
    end else if (out_ready) begin
      state      <= EMPTY;
    end
  end

  assign out_valid = (state == FULL);

endmodule
